// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - IO base nibble and register address map shared by the IO controller
package io_pkg;

    localparam logic [3:0]  IO_BASE        = 4'h8;

    localparam logic [31:0] ADDR_TX_STATUS = {IO_BASE, 28'h000_0000};
    localparam logic [31:0] ADDR_RX_STATUS = {IO_BASE, 28'h000_0004};
    localparam logic [31:0] ADDR_TX_DATA   = {IO_BASE, 28'h000_0008};
    localparam logic [31:0] ADDR_RX_DATA   = {IO_BASE, 28'h000_000C};
    localparam logic [31:0] ADDR_CYC_CNT   = {IO_BASE, 28'h000_0010};
    localparam logic [31:0] ADDR_INST_CNT  = {IO_BASE, 28'h000_0014};
    localparam logic [31:0] ADDR_CNT_CLR   = {IO_BASE, 28'h000_0018};

endpackage

// File: rtl/io_rx_fifo.sv
// rtl/io_rx_fifo.sv - power-of-two byte FIFO buffering UART receive data
module io_rx_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Pop is refused when empty, push when full; pointers wrap naturally at DEPTH.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards any buffered bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are meaningless outside the occupied window.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// rtl/io_bus_ctrl.sv - memory-mapped UART and performance counter controller
module io_bus_ctrl
    import io_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        instr_retire,
    output logic        io_sel,
    output logic [31:0] rdata,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);

    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  din_q, din_d;
    logic        din_vld_q, din_vld_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] inst_q, inst_d;
    logic        rx_full, rx_empty, rx_pop;
    logic [7:0]  rx_head;
    logic        tx_ready, cnt_clr, tx_wr;
    logic        unused_wdata_hi;

    assign io_sel          = (addr[31:28] == IO_BASE);
    assign rdata           = rdata_q;
    assign uart_din        = din_q;
    assign uart_din_valid  = din_vld_q;
    assign uart_dout_ready = !rx_full;
    assign tx_ready        = !din_vld_q;
    assign unused_wdata_hi = ^wdata[31:8];

    io_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (uart_dout_valid),
        .din_i   (uart_dout),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head)
    );

    // Decode accesses and compute next read data, TX holding register and counters.
    always_comb begin
        rx_pop  = re && (addr == ADDR_RX_DATA);
        tx_wr   = we && (addr == ADDR_TX_DATA);
        cnt_clr = we && (addr == ADDR_CNT_CLR);

        rdata_d = rdata_q;
        if (re) begin
            case (addr)
                ADDR_TX_STATUS: rdata_d = {31'b0, tx_ready};
                ADDR_RX_STATUS: rdata_d = {31'b0, !rx_empty};
                ADDR_RX_DATA:   rdata_d = {24'b0, rx_empty ? 8'h00 : rx_head};
                ADDR_CYC_CNT:   rdata_d = cyc_q;
                ADDR_INST_CNT:  rdata_d = inst_q;
                default:        rdata_d = 32'h0;
            endcase
        end

        din_d     = din_q;
        din_vld_d = din_vld_q;
        if (tx_wr && tx_ready) begin
            din_d     = wdata[7:0];
            din_vld_d = 1'b1;
        end else if (din_vld_q && uart_din_ready) begin
            din_vld_d = 1'b0;
        end

        cyc_d  = cnt_clr ? 32'h0 : cyc_q + 32'd1;
        inst_d = cnt_clr ? 32'h0 : inst_q + {31'b0, instr_retire};
    end

    // Register stage for read data, TX handshake and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q   <= '0;
            din_q     <= '0;
            din_vld_q <= 1'b0;
            cyc_q     <= '0;
            inst_q    <= '0;
        end else begin
            rdata_q   <= rdata_d;
            din_q     <= din_d;
            din_vld_q <= din_vld_d;
            cyc_q     <= cyc_d;
            inst_q    <= inst_d;
        end
    end

endmodule
